posit_normalize: RTL and testbench

// - Encoder back from the denormalized posit form {sign, inf, zero, scale, fraction} to packed posit bits.
// - Sits at the tail of every arithmetic datapath, after the core op has produced a denormalized result.
// - Performs regime/exponent encoding, round-to-nearest-even, clamping, sign handling and special cases.
// - 3-stage pipeline with valid/ready on both sides.

---
 rtl/posit_normalize_pkg.sv | 35 +++
 rtl/posit_normalize_rne.sv | 39 +++
 rtl/posit_normalize.sv | 156 +++++++++++++++
 tb/tb_posit_normalize.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_normalize_pkg.sv
// Shared posit definitions: field-width helpers, special bit patterns and the
// flag record that rides alongside a value through the normalizer pipeline.
package posit_defines;

  // Scale must span +/-(N-2)*2^ES with headroom so out-of-range inputs can be seen.
  function automatic int get_scale_width(input int n, input int es);
    return $clog2(n - 1) + es + 1;
  endfunction

  // Widest fraction a posit can carry: sign, two regime bits and ES exponent bits removed.
  function automatic int get_fraction_width(input int n, input int es);
    return n - 3 - es;
  endfunction

  function automatic logic [63:0] posit_maxpos(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int n);
    return (n > 1) ? 64'd1 : 64'd0;
  endfunction

  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

  typedef struct packed {
    logic sign;
    logic inf;
    logic zero;
    logic clamp_hi;
    logic clamp_lo;
  } posit_flags_t;

endpackage

// File: rtl/posit_normalize_rne.sv
// Round-to-nearest-even on an N-1 bit posit magnitude, with saturation so the
// result is never zero and never exceeds maxpos.
module posit_rne_round
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH = 8
) (
  input  logic [POSIT_WIDTH-2:0] mag,
  input  logic                   g,
  input  logic                   s,
  input  logic                   clamp_hi,
  input  logic                   clamp_lo,
  output logic [POSIT_WIDTH-2:0] rounded
);

  localparam int N = POSIT_WIDTH;
  localparam logic [N-2:0] MAX_MAG = (N-1)'(posit_maxpos(N));
  localparam logic [N-2:0] MIN_MAG = (N-1)'(posit_minpos(N));

  logic         round_up;
  logic [N-1:0] sum;

  always_comb begin
    round_up = g && (s || mag[0]);
    sum      = {1'b0, mag} + {{(N-1){1'b0}}, round_up};
    if (clamp_hi) begin
      rounded = MAX_MAG;
    end else if (clamp_lo) begin
      rounded = MIN_MAG;
    end else if (sum[N-1]) begin
      rounded = MAX_MAG;
    end else if (sum[N-2:0] == '0) begin
      rounded = MIN_MAG;
    end else begin
      rounded = sum[N-2:0];
    end
  end

endmodule

// File: rtl/posit_normalize.sv
// Three-stage encoder from denormalized {sign, inf, zero, scale, fraction} to
// packed posit bits: classify/clamp, regime assembly, then round and finish.
module posit_normalize
  import posit_defines::*;
#(
  parameter int  POSIT_WIDTH = 8,
  parameter int  POSIT_ES    = 0,
  localparam int SCALE_W     = get_scale_width(POSIT_WIDTH, POSIT_ES),
  localparam int FRAC_W      = get_fraction_width(POSIT_WIDTH, POSIT_ES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic                   in_inf,
  input  logic                   in_zero,
  input  logic [SCALE_W-1:0]     in_scale,
  input  logic [FRAC_W-1:0]      in_fraction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [POSIT_WIDTH-1:0] out_posit
);

  localparam int N    = POSIT_WIDTH;
  localparam int ES   = POSIT_ES;
  localparam int EF_W = ES + FRAC_W;
  localparam int W2   = 2 * N;
  localparam logic signed [SCALE_W-1:0] MAX_SCALE = SCALE_W'((N - 2) << ES);
  localparam logic [N-1:0] NAR = N'(posit_nar(N));

  typedef struct packed {
    posit_flags_t               flags;
    logic signed [SCALE_W-1:0]  k;
    logic [EF_W-1:0]            ef;
  } s1_rec_t;

  typedef struct packed {
    posit_flags_t flags;
    logic [N-2:0] mag;
    logic         g;
    logic         s;
  } s2_rec_t;

  // Handshake: a stage loads when it is empty or its content moves on this cycle.
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic ld1, ld2, ld3;

  always_comb begin
    ld3      = !v3_q || out_ready;
    ld2      = !v2_q || ld3;
    ld1      = !v1_q || ld2;
    in_ready = ld1;
    v1_d     = ld1 ? in_valid : v1_q;
    v2_d     = ld2 ? v1_q : v2_q;
    v3_d     = ld3 ? v2_q : v3_q;
  end

  // S1: clamp the scale, split into regime k and the exponent+fraction tail.
  logic signed [SCALE_W-1:0] scale_s, scale_c;
  logic [EF_W-1:0]           ef_c;
  s1_rec_t                   s1_c, s1_d, s1_q;

  always_comb begin
    scale_s             = signed'(in_scale);
    s1_c                = '0;
    s1_c.flags.sign     = in_sign;
    s1_c.flags.inf      = in_inf;
    s1_c.flags.zero     = in_zero && !in_inf;
    s1_c.flags.clamp_hi = scale_s > MAX_SCALE;
    s1_c.flags.clamp_lo = scale_s < -MAX_SCALE;
    if (s1_c.flags.clamp_hi) begin
      scale_c = MAX_SCALE;
    end else if (s1_c.flags.clamp_lo) begin
      scale_c = -MAX_SCALE;
    end else begin
      scale_c = scale_s;
    end
    s1_c.k  = scale_c >>> ES;
    s1_c.ef = ef_c;
    s1_d    = ld1 ? s1_c : s1_q;
  end

  if (ES == 0) begin : g_no_exp
    assign ef_c = in_fraction;
  end else begin : g_exp
    assign ef_c = {scale_c[ES-1:0], in_fraction};
  end

  // S2: an arithmetic shift of {10,...} or {01,...} grows the regime run in place.
  logic [SCALE_W-1:0] shamt;
  logic [W2-1:0]      seed, word;
  s2_rec_t            s2_c, s2_d, s2_q;

  always_comb begin
    shamt      = s1_q.k[SCALE_W-1] ? ~s1_q.k : s1_q.k;
    seed       = {(s1_q.k[SCALE_W-1] ? 2'b01 : 2'b10), s1_q.ef, {(W2-2-EF_W){1'b0}}};
    word       = $signed(seed) >>> shamt;
    s2_c.flags = s1_q.flags;
    s2_c.mag   = word[W2-1 -: N-1];
    s2_c.g     = word[N];
    s2_c.s     = |word[N-1:0];
    s2_d       = ld2 ? s2_c : s2_q;
  end

  // S3: round, apply sign, resolve specials.
  logic [N-2:0] rounded;
  logic [N-1:0] mag_full, posit_c, posit_d, posit_q;

  posit_rne_round #(
    .POSIT_WIDTH(N)
  ) u_round (
    .mag      (s2_q.mag),
    .g        (s2_q.g),
    .s        (s2_q.s),
    .clamp_hi (s2_q.flags.clamp_hi),
    .clamp_lo (s2_q.flags.clamp_lo),
    .rounded  (rounded)
  );

  always_comb begin
    mag_full = {1'b0, rounded};
    if (s2_q.flags.inf) begin
      posit_c = NAR;
    end else if (s2_q.flags.zero) begin
      posit_c = '0;
    end else if (s2_q.flags.sign) begin
      posit_c = ~mag_full + 1'b1;
    end else begin
      posit_c = mag_full;
    end
    posit_d = ld3 ? posit_c : posit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      posit_q <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      posit_q <= posit_d;
    end
  end

  assign out_valid = v3_q;
  assign out_posit = posit_q;

endmodule

// File: tb/tb_posit_normalize.sv
// Scoreboard bench for posit_normalize (N=8, ES=0): directed encodings, random
// operands against a bit-string reference model, backpressure and mid-stream reset.
module tb_posit_normalize;

  localparam int N  = 8;
  localparam int ES = 0;
  localparam int SW = 4;
  localparam int FW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sign, in_inf, in_zero;
  logic [SW-1:0] in_scale;
  logic [FW-1:0] in_fraction;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_posit;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [N-1:0] exp_q[$];
  int           acc_q[$];
  bit           lat_q[$];

  int           inflight = 0;
  logic         stalled_prev = 1'b0;
  logic [N-1:0] held = '0;
  bit           chk_on = 1'b0;
  int           or_mode = 0;
  int           ph = 0;

  posit_normalize #(
    .POSIT_WIDTH(N),
    .POSIT_ES(ES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_inf      (in_inf),
    .in_zero     (in_zero),
    .in_scale    (in_scale),
    .in_fraction (in_fraction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_posit   (out_posit)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always ready, 1 = repeating 1-0-0-1, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: write out the unbounded posit bit string, keep N-1 bits, round on the rest.
  function automatic logic [N-1:0] model(input bit sg, input bit inf, input bit zr,
                                         input int scale, input int frac);
    bit           bq[$];
    int           p, maxs, k, e, mag, g, st, maxp;
    logic [N-1:0] r;
    p    = 1 << ES;
    maxs = (N - 2) * p;
    maxp = (1 << (N - 1)) - 1;
    r    = '0;
    if (inf) begin
      r[N-1] = 1'b1;
      return r;
    end
    if (zr) return r;
    if (scale > maxs) begin
      mag = maxp;
    end else if (scale < -maxs) begin
      mag = 1;
    end else begin
      k = (scale >= 0) ? scale / p : -((-scale + p - 1) / p);
      e = scale - k * p;
      if (k >= 0) begin
        repeat (k + 1) bq.push_back(1'b1);
        bq.push_back(1'b0);
      end else begin
        repeat (-k) bq.push_back(1'b0);
        bq.push_back(1'b1);
      end
      for (int i = ES - 1; i >= 0; i--) bq.push_back(e[i]);
      for (int i = FW - 1; i >= 0; i--) bq.push_back(frac[i]);
      mag = 0;
      for (int i = 0; i < N - 1; i++) mag = mag * 2 + ((i < bq.size()) ? int'(bq[i]) : 0);
      g  = (bq.size() > N - 1) ? int'(bq[N-1]) : 0;
      st = 0;
      for (int i = N; i < bq.size(); i++) st = st | int'(bq[i]);
      if (g != 0 && (st != 0 || (mag % 2) == 1)) mag++;
      if (mag > maxp) mag = maxp;
      if (mag == 0) mag = 1;
    end
    if (sg) mag = (1 << N) - mag;
    r = mag[N-1:0];
    return r;
  endfunction

  // Driver: present one operand, hold until accepted, record the expectation.
  task automatic drive(input bit sg, input bit inf, input bit zr, input int scale,
                       input int frac, input logic [N-1:0] exp, input bit lat);
    int waitc = 0;
    in_sign     = sg;
    in_inf      = inf;
    in_zero     = zr;
    in_scale    = SW'(scale);
    in_fraction = FW'(frac);
    in_valid    = 1'b1;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      waitc++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc + 1);
      lat_q.push_back(lat);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [N-1:0] e;
    int           a;
    bit           l;
    if (rst) begin
      inflight     = 0;
      stalled_prev = 1'b0;
      exp_q.delete();
      acc_q.delete();
      lat_q.delete();
    end else if (chk_on) begin
      check("in_ready_rule", 32'(in_ready), 32'(!(inflight == 3 && !out_ready)));
      if (stalled_prev && out_valid) check("stall_hold", 32'(out_posit), 32'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got %0h, nothing expected", out_posit);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          l = lat_q.pop_front();
          check("data", 32'(out_posit), 32'(e));
          if (l) check("latency", 32'(cyc + 1 - a), 32'd3);
        end
      end
      stalled_prev = out_valid && !out_ready;
      held         = out_posit;
      inflight     = inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  // Directed table: sign, inf, zero, scale, fraction, expected posit
  bit   t_sg [20] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  bit   t_inf[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
  bit   t_zr [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
  int   t_sc [20] = '{0, 0, 0, 6, 7, -6, -8, 7, 2, 2, 2, 0, 0, 0, 3, -1, -1, 5, -7, -5};
  int   t_fr [20] = '{0, 0, 16, 0, 0, 0, 0, 0, 2, 6, 3, 0, 0, 0, 5, 0, 31, 31, 31, 24};
  logic [7:0] t_ex[20] = '{8'h40, 8'hC0, 8'h50, 8'h7F, 8'h7F, 8'h01, 8'h01, 8'h81,
                           8'h70, 8'h72, 8'h71, 8'h80, 8'h00, 8'h80, 8'h80, 8'hE0,
                           8'h3F, 8'h7F, 8'h01, 8'h04};

  task automatic drive_random(input bit lat);
    bit sg, inf, zr;
    int sc, fr;
    sg  = 1'($urandom_range(0, 1));
    inf = ($urandom_range(0, 9) == 0);
    zr  = ($urandom_range(0, 9) == 0);
    sc  = int'($urandom_range(0, 15)) - 8;
    fr  = int'($urandom_range(0, 31));
    drive(sg, inf, zr, sc, fr, model(sg, inf, zr, sc, fr), lat);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_sign     = 1'b0;
    in_inf      = 1'b0;
    in_zero     = 1'b0;
    in_scale    = '0;
    in_fraction = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_posit", 32'(out_posit), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk_on = 1'b1;

    for (int i = 0; i < 20; i++) drive(t_sg[i], t_inf[i], t_zr[i], t_sc[i], t_fr[i], t_ex[i], 1'b1);
    drain();

    for (int i = 0; i < 40; i++) drive_random(1'b1);
    drain();

    or_mode = 1;
    for (int i = 0; i < 10; i++) drive_random(1'b0);
    drain();
    or_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Fill the pipe while stalled, then reset with three operands in flight.
    or_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) drive_random(1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_posit", 32'(out_posit), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    or_mode = 0;
    drive(1'b0, 1'b0, 1'b0, 0, 16, 8'h50, 1'b1);
    drain();
    drive_random(1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
